// File: rtl/bk_mem_pkg.sv
// rtl/bk_mem_pkg.sv - shared types and constants for the data-memory arbiter
package bk_mem_pkg;

  // Words per byte-lane RAM bank
  localparam int RAM_DEPTH = 64;

  // Arbiter ownership state
  typedef enum logic {
    ARB      = 1'b0,
    DBG_LOCK = 1'b1
  } arb_state_t;

  // Requester that owns the access (grant winner or pending read return)
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/debug arbiter in front of four byte-lane data RAM banks
module dmem_arbiter
  import bk_mem_pkg::*;
#(
  parameter int ADDR_W   = $clog2(RAM_DEPTH),
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [31:0]       core_addr,
  input  logic [3:0]        core_be,
  input  logic [31:0]       core_wdata,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [31:0]       core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [3:0]        dbg_be,
  input  logic [31:0]       dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic [3:0]        ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              err
);

  localparam int              WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_t        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  owner_t            rd_owner, rd_owner_nxt;
  logic              rd_oor, rd_oor_nxt;

  owner_t            winner;
  logic              win_we;
  logic [31:0]       win_addr;
  logic [3:0]        win_be;
  logic [31:0]       win_wdata;
  logic              win_oor;
  logic              win_access;
  logic              unused_addr_bits;

  // Pick the winner, track the lock and count how long debug has been starved
  always_comb begin
    winner    = OWN_NONE;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    if (!rst) begin
      if (state == DBG_LOCK && dbg_lock) begin
        if (dbg_req) winner = OWN_DBG;
      end else if (dbg_req && (!core_req || wait_cnt == WAIT_MAX)) begin
        winner = OWN_DBG;
      end else if (core_req) begin
        winner = OWN_CORE;
      end

      // Lock is taken on a locked debug grant and held until dbg_lock drops
      state_nxt = (dbg_lock && (winner == OWN_DBG || state == DBG_LOCK)) ? DBG_LOCK : ARB;

      if (!dbg_req || winner == OWN_DBG) begin
        wait_nxt = '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_nxt = wait_cnt + 1'b1;
      end
    end
  end

  // Steer the winning requester's fields onto the RAM side
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_be    = '0;
    win_wdata = '0;
    case (winner)
      OWN_CORE: begin
        win_we    = core_we;
        win_addr  = core_addr;
        win_be    = core_be;
        win_wdata = core_wdata;
      end
      OWN_DBG: begin
        win_we    = dbg_we;
        win_addr  = dbg_addr;
        win_be    = dbg_be;
        win_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  // Byte offset bits are irrelevant to a word-wide bank access
  assign unused_addr_bits = ^win_addr[1:0];

  assign win_oor    = (winner != OWN_NONE) && (win_addr[31:ADDR_W+2] != '0);
  assign win_access = (winner != OWN_NONE) && !win_oor;

  assign ram_en     = win_access ? win_be : 4'h0;
  assign ram_we     = win_access && win_we;
  assign ram_addr   = win_addr[ADDR_W+1:2];
  assign ram_wdata  = win_wdata;
  assign err        = win_oor;

  assign dbg_gnt    = (winner == OWN_DBG);
  assign core_stall = core_req && !rst && (winner != OWN_CORE);

  // Remember who is owed read data next cycle (out-of-range reads still return)
  always_comb begin
    rd_owner_nxt = OWN_NONE;
    rd_oor_nxt   = 1'b0;
    if (winner != OWN_NONE && !win_we) begin
      rd_owner_nxt = winner;
      rd_oor_nxt   = win_oor;
    end
  end

  // State, starvation counter and read-return bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB;
      wait_cnt <= '0;
      rd_owner <= OWN_NONE;
      rd_oor   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      rd_owner <= rd_owner_nxt;
      rd_oor   <= rd_oor_nxt;
    end
  end

  // Route registered bank data back to the port that issued the read
  always_comb begin
    core_rvalid = 1'b0;
    core_rdata  = '0;
    dbg_rvalid  = 1'b0;
    dbg_rdata   = '0;
    case (rd_owner)
      OWN_CORE: begin
        core_rvalid = 1'b1;
        core_rdata  = rd_oor ? 32'h0 : ram_rdata;
      end
      OWN_DBG: begin
        dbg_rvalid = 1'b1;
        dbg_rdata  = rd_oor ? 32'h0 : ram_rdata;
      end
      default: ;
    endcase
  end

endmodule
